// File: rtl/sdram_dl_writer_if.sv
// Bundles the ioctl download stream and the ch3 write channel of the SDRAM download writer.
// The slave modport is the writer itself; master is the host/controller side.
interface sdram_dl_writer_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [26:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic [25:0] ch3_addr;
    logic [15:0] ch3_din;
    logic [1:0]  ch3_be;
    logic        ch3_req;
    logic        ch3_rnw;
    logic        ch3_ready;
    logic        done;
    logic        overflow;

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ch3_ready,
        output ioctl_wait, ch3_addr, ch3_din, ch3_be, ch3_req, ch3_rnw, done, overflow
    );

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ch3_ready,
        input  ioctl_wait, ch3_addr, ch3_din, ch3_be, ch3_req, ch3_rnw, done, overflow
    );
endinterface

// File: rtl/sdram_dl_writer.sv
// Packs the byte-wide ioctl download into 16-bit words with byte enables, queues them
// in a small FIFO and feeds them to SDRAM ch3 as single-word level-held write requests.
module sdram_dl_writer #(
    parameter logic [26:0] BASE_ADDR  = 27'h0000000,
    parameter int          FIFO_DEPTH = 4,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input logic clk,
    input logic reset,
    sdram_dl_writer_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 26 + 16 + 2;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] WAIT_CNT = CW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    // Returns {be, din} for one byte placed in its lane.
    function automatic logic [17:0] lane_word(input logic [7:0] data, input logic lane);
        if ((lane ^ BIG_ENDIAN) == 1'b1) return {2'b10, data, 8'h00};
        else                             return {2'b01, 8'h00, data};
    endfunction

    logic          dl_prev_reg;
    logic          pend_valid_reg, pend_valid_next;
    logic [25:0]   pend_waddr_reg, pend_waddr_next;
    logic [7:0]    pend_data_reg, pend_data_next;
    logic          pend_lane_reg, pend_lane_next;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic          wait_reg, overflow_reg, fell_reg, done_reg;
    state_t        state_reg, state_next;
    logic [25:0]   addr_reg;
    logic [15:0]   din_reg;
    logic [1:0]    be_reg;
    logic          req_reg;

    logic [26:0]   byte_addr;
    logic          wr_en, dl_rise, dl_fall;
    logic          push, accept, drop, pop, load, done_cond;
    logic [17:0]   push_word;
    logic [EW-1:0] push_entry;

    assign byte_addr = BASE_ADDR + bus.ioctl_addr;
    assign wr_en     = bus.ioctl_wr & bus.ioctl_download;
    assign dl_rise   = bus.ioctl_download & ~dl_prev_reg;
    assign dl_fall   = ~bus.ioctl_download & dl_prev_reg;

    // Byte assembly: every push carries the pending byte, optionally merged with the new one.
    always_comb begin
        pend_valid_next = pend_valid_reg;
        pend_waddr_next = pend_waddr_reg;
        pend_data_next  = pend_data_reg;
        pend_lane_next  = pend_lane_reg;
        push            = 1'b0;
        push_word       = lane_word(pend_data_reg, pend_lane_reg);
        if (wr_en) begin
            if (pend_valid_reg && (pend_waddr_reg == byte_addr[26:1])
                    && (pend_lane_reg != byte_addr[0])) begin
                push            = 1'b1;
                push_word       = push_word | lane_word(bus.ioctl_dout, byte_addr[0]);
                pend_valid_next = 1'b0;
            end else begin
                push            = pend_valid_reg;
                pend_valid_next = 1'b1;
                pend_waddr_next = byte_addr[26:1];
                pend_data_next  = bus.ioctl_dout;
                pend_lane_next  = byte_addr[0];
            end
        end else if (dl_fall && pend_valid_reg) begin
            push            = 1'b1;
            pend_valid_next = 1'b0;
        end
    end

    assign push_entry = {pend_waddr_reg, push_word[15:0], push_word[17:16]};
    assign accept     = push && (count_reg != FULL_CNT);
    assign drop       = push && (count_reg == FULL_CNT);

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        pop        = 1'b0;
        case (state_reg)
            IDLE: if (count_reg != '0) begin
                load       = 1'b1;
                state_next = REQ;
            end
            REQ: if (bus.ch3_ready) begin
                pop        = 1'b1;
                state_next = GAP;
            end
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        if (accept && !pop)      count_next = count_reg + CNT_ONE;
        else if (!accept && pop) count_next = count_reg - CNT_ONE;
    end

    assign done_cond = fell_reg && (count_reg == '0) && !pend_valid_reg && (state_reg == IDLE);

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr_reg] <= push_entry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dl_prev_reg    <= 1'b0;
            pend_valid_reg <= 1'b0;
            pend_waddr_reg <= '0;
            pend_data_reg  <= '0;
            pend_lane_reg  <= 1'b0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            wait_reg       <= 1'b0;
            overflow_reg   <= 1'b0;
            fell_reg       <= 1'b0;
            done_reg       <= 1'b0;
            addr_reg       <= '0;
            din_reg        <= '0;
            be_reg         <= '0;
            req_reg        <= 1'b0;
        end else begin
            dl_prev_reg    <= bus.ioctl_download;
            pend_valid_reg <= pend_valid_next;
            pend_waddr_reg <= pend_waddr_next;
            pend_data_reg  <= pend_data_next;
            pend_lane_reg  <= pend_lane_next;
            if (accept) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)    rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            count_reg <= count_next;
            // Raised one slot early so an in-flight strobe or flush still has room.
            wait_reg  <= (count_next >= WAIT_CNT);
            if (drop)         overflow_reg <= 1'b1;
            else if (dl_rise) overflow_reg <= 1'b0;
            if (load) begin
                {addr_reg, din_reg, be_reg} <= mem[rd_ptr_reg];
                req_reg <= 1'b1;
            end else if (pop) begin
                req_reg <= 1'b0;
            end
            done_reg <= done_cond;
            // A restarted download cancels the completion of the one still draining.
            if (dl_rise)        fell_reg <= 1'b0;
            else if (dl_fall)   fell_reg <= 1'b1;
            else if (done_cond) fell_reg <= 1'b0;
        end
    end

    assign bus.ioctl_wait = wait_reg;
    assign bus.ch3_addr   = addr_reg;
    assign bus.ch3_din    = din_reg;
    assign bus.ch3_be     = be_reg;
    assign bus.ch3_req    = req_reg;
    assign bus.ch3_rnw    = 1'b0;
    assign bus.done       = done_reg;
    assign bus.overflow   = overflow_reg;
endmodule

// File: doc/sdram_dl_writer.md
Name: sdram_dl_writer

Overview:
- Upstream feeder for the SDRAM controller's read/write channel (ch3).
- Accepts the byte-wide ROM download stream from the HPS ioctl interface and packs byte pairs into 16-bit words with byte enables.
- Buffers the packed words in a small FIFO and issues single-word write requests using the controller's level-held, rising-edge-detected req / one-cycle ready protocol.
- Applies back-pressure to the host through ioctl_wait.

Parameters:
- BASE_ADDR, 27'h0000000: byte offset added to ioctl_addr; must be even.
- FIFO_DEPTH, 4: word FIFO entries; power of two, minimum 2.
- BIG_ENDIAN, 0: 0 = even byte on din[7:0] with be[0]; 1 = even byte on din[15:8] with be[1].

Ports:
- clk  in  1  system clock; same clock as the SDRAM controller.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  high for the duration of a download.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  27  byte address of ioctl_dout.
- ioctl_dout  in  8  download byte.
- ioctl_wait  out  1  host must stall further ioctl_wr.
- ch3_addr  out  26  word address [26:1] to the controller.
- ch3_din  out  16  write data.
- ch3_be  out  2  byte enables; be[0] = low byte.
- ch3_req  out  1  write request, level-held.
- ch3_rnw  out  1  tied 0 (write only).
- ch3_ready  in  1  one-cycle completion pulse from the controller.
- done  out  1  one-cycle pulse when the download has ended and all data is written.
- overflow  out  1  sticky flag: a byte was dropped.

Behaviour:
- Reset values: all outputs 0; FIFO empty; no pending byte; FSM in IDLE. Reset mid-transfer drops ch3_req immediately, and any later ch3_ready is ignored.
- Byte assembly: one pending-byte register holding address, data and lane.
  - ioctl_wr with the pending byte present and the same word address (ioctl_addr[26:1]) in the opposite lane: push the merged word with be=2'b11; pending is cleared.
  - ioctl_wr with the pending byte present but a different word, or the same lane: push the pending byte alone (single be bit, other lane 8'h00); the new byte becomes pending.
  - ioctl_wr with no pending byte: the byte becomes pending; no push.
  - Result: at most one FIFO push per cycle.
- Flush: on the falling edge of ioctl_download, a pending byte is pushed alone.
- Word address = (BASE_ADDR + ioctl_addr)[26:1], truncated to 26 bits; wraps silently.
- FIFO: synchronous, count-based.
  - ioctl_wait = 1 whenever count >= FIFO_DEPTH-1, registered. This keeps one slot free for an in-flight strobe or flush.
  - A push while count == FIFO_DEPTH drops the word and sets overflow. overflow clears only on reset or on the rising edge of ioctl_download.
  - Push and pop in the same cycle leave the count unchanged.
- Write FSM:
  - IDLE: if the FIFO is non-empty, register the head into ch3_addr/ch3_din/ch3_be and set ch3_req=1 the same edge -> REQ.
  - REQ: ch3_addr/ch3_din/ch3_be/ch3_req are held stable. On ch3_ready: ch3_req<=0, pop the FIFO -> GAP.
  - GAP: ch3_req stays 0 for exactly one cycle, guaranteeing a fresh rising edge -> IDLE.
- Latency: a word pushed at edge N gives ch3_req high after edge N+1. Minimum spacing between requests is 3 cycles plus the controller's response time.
- ch3_ready outside REQ is ignored.
- done: pulses one cycle when all four hold: download has fallen (latched), FIFO empty, no pending byte, FSM in IDLE. The latch clears after the pulse and on the rising edge of ioctl_download.
- A new download starting while the previous one is still draining is allowed. Data order is preserved, and done is suppressed for the earlier download.

Test Plan:
- Bytes 0x11@0, 0x22@1, 0x33@2, 0x44@3, then download falls (BASE 0, LE) -> two writes: addr 0 din 16'h2211 be 11; addr 1 din 16'h4433 be 11; then one done pulse.
- Lone 0xAA@5, then download falls -> one write: addr 2 din 16'hAA00 be 10. BIG_ENDIAN=1 variant -> din 16'h00AA be 01.
- Bytes @0 then @4 -> addr 0 be 01 written when the @4 byte arrives; @4 written at the flush (addr 2 be 01).
- ch3_ready held off for 40 cycles while strobing bytes every cycle -> ioctl_wait rises at count 3 (depth 4). If the bench ignores wait, overflow sets on the 5th unaccepted word. ch3_req/addr/din stay stable throughout.
- BASE_ADDR=27'h7FFFFFE, byte@2 -> ch3_addr wraps to 26'h0000000.
- Assert reset while ch3_req=1 -> ch3_req=0 the next cycle, a late ch3_ready is ignored, FIFO empty, no done pulse.
